// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over req/ack and hands words to decode over valid/ready.
// Define FETCH_MISALIGN_TRAP_EN to trap on a misaligned next PC instead of silently aligning it.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            pc_src,
  input  logic            jalr,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic [31:0]     instr_count,
  output logic            fetch_trap
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID,
    TRAP
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] sel_pc;
  logic            misaligned;

  assign imem_addr = pc;
  assign op        = instr[6:0];
  assign funct3    = instr[14:12];
  assign pc_plus4  = pc_out + XLEN'(4);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    next_pc = pc_plus4;
    if (jalr) begin
      next_pc = {jalr_target[XLEN-1:1], 1'b0};
    end else if (pc_src) begin
      next_pc = branch_target;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign sel_pc     = next_pc;
  assign misaligned = |next_pc[1:0];
`else
  // Without the trap, the low two bits are dropped so fetch stays word aligned.
  assign sel_pc     = next_pc & ~XLEN'(3);
  assign misaligned = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only; blocking ones here would race other flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= NOP;
      pc_out      <= RESET_PC;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          imem_req <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            pc_out      <= pc;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            instr_count <= instr_count + 32'd1;
            pc          <= sel_pc;
            if (misaligned) begin
              state <= TRAP;
            end else begin
              imem_req <= 1'b1;
              state    <= REQ;
            end
          end
        end
        TRAP: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= TRAP;
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky until reset; set on the same edge that enters TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_trap <= 1'b0;
    end else if (state == VALID && instr_ready && misaligned) begin
      fetch_trap <= 1'b1;
    end
  end
`else
  assign fetch_trap = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, stalls, redirects, PC wrap, mid-fetch reset
// and the misaligned-target case (expectation follows FETCH_MISALIGN_TRAP_EN).
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        pc_src = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] jalr_target = '0;
  logic [31:0] instr_count;
  logic        fetch_trap;

  // Second instance starting at the top of the address space, with an always-acking memory.
  logic        h_req;
  logic [31:0] h_addr;
  logic        h_valid;
  logic [31:0] h_instr;
  logic [6:0]  h_op;
  logic [2:0]  h_funct3;
  logic [31:0] h_pc_out;
  logic [31:0] h_pc_plus4;
  logic [31:0] h_count;
  logic        h_trap;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .op(op), .funct3(funct3),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .pc_src(pc_src), .jalr(jalr),
    .branch_target(branch_target), .jalr_target(jalr_target),
    .instr_count(instr_count), .fetch_trap(fetch_trap)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .rst_n(rst_n),
    .imem_req(h_req), .imem_addr(h_addr), .imem_ack(h_req), .imem_rdata(NOP),
    .instr_valid(h_valid), .instr_ready(1'b1), .instr(h_instr), .op(h_op), .funct3(h_funct3),
    .pc_out(h_pc_out), .pc_plus4(h_pc_plus4), .pc_src(1'b0), .jalr(1'b0),
    .branch_target(32'h0), .jalr_target(32'h0),
    .instr_count(h_count), .fetch_trap(h_trap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the fetch request, sampled on falling edges.
  task automatic wait_req();
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
    check("req_seen", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data, input int delay);
    wait_req();
    check("fetch_addr", imem_addr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("req_hold", {31'b0, imem_req}, 32'd1);
      check("addr_hold", imem_addr, exp_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check("valid_after_ack", {31'b0, instr_valid}, 32'd1);
    check("instr", instr, data);
    check("pc_out", pc_out, exp_addr);
    check("req_dropped", {31'b0, imem_req}, 32'd0);
  endtask

  task automatic do_retire(input logic src, input logic j, input logic [31:0] bt,
                           input logic [31:0] jt, input logic [31:0] exp_count);
    instr_ready   = 1'b1;
    pc_src        = src;
    jalr          = j;
    branch_target = bt;
    jalr_target   = jt;
    @(negedge clk);
    instr_ready   = 1'b0;
    pc_src        = 1'b0;
    jalr          = 1'b0;
    branch_target = '0;
    jalr_target   = '0;
    check("count", instr_count, exp_count);
    check("valid_cleared", {31'b0, instr_valid}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_pc_out"}, pc_out, 32'h0);
    check({tag, "_count"}, instr_count, 32'h0);
    check({tag, "_trap"}, {31'b0, fetch_trap}, 32'd0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    check("hi_rst_addr", h_addr, 32'hFFFF_FFFC);

    // Release; the high-PC instance acks immediately, so its sequence is fully determined.
    rst_n = 1'b1;
    @(negedge clk);
    check("hi_req", {31'b0, h_req}, 32'd1);
    check("hi_addr0", h_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("hi_valid", {31'b0, h_valid}, 32'd1);
    check("hi_pc_out", h_pc_out, 32'hFFFF_FFFC);
    check("hi_pc_plus4_wrap", h_pc_plus4, 32'h0);
    @(negedge clk);
    check("hi_addr_wrap", h_addr, 32'h0);
    check("hi_count", h_count, 32'd1);

    // Sequential fetches: 0x0, 0x4, 0x8.
    do_fetch(32'h0, 32'h0050_0093, 1);
    check("op0", {25'b0, op}, 32'h13);
    check("funct3_0", {29'b0, funct3}, 32'h0);
    check("pc_plus4_0", pc_plus4, 32'h4);
    do_retire(1'b0, 1'b0, 32'h0, 32'h0, 32'd1);

    do_fetch(32'h4, 32'h0020_a023, 1);
    check("op1", {25'b0, op}, 32'h23);
    check("funct3_1", {29'b0, funct3}, 32'h2);
    do_retire(1'b0, 1'b0, 32'h0, 32'h0, 32'd2);

    // Same-cycle ack, then hold ready low with a redirect on the inputs that must be ignored.
    do_fetch(32'h8, 32'hfe00_08e3, 0);
    pc_src        = 1'b1;
    branch_target = 32'h300;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_instr", instr, 32'hfe00_08e3);
      check("stall_op", {25'b0, op}, 32'h63);
      check("stall_pc_out", pc_out, 32'h8);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_count", instr_count, 32'd2);
    end
    pc_src        = 1'b0;
    branch_target = '0;
    do_retire(1'b0, 1'b0, 32'h0, 32'h0, 32'd3);

    // Branch redirect to 0x100.
    do_fetch(32'hC, 32'h0000_0063, 1);
    do_retire(1'b1, 1'b0, 32'h100, 32'h7777_7770, 32'd4);

    // JALR wins over pc_src; bit 0 of the target is cleared.
    do_fetch(32'h100, 32'h0000_8067, 1);
    do_retire(1'b1, 1'b1, 32'h400, 32'h205, 32'd5);

    // Reset while the request to 0x204 is outstanding.
    wait_req();
    check("jalr_addr", imem_addr, 32'h204);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    do_fetch(32'h0, 32'h00b0_0193, 1);
    do_retire(1'b0, 1'b0, 32'h0, 32'h0, 32'd1);
    do_fetch(32'h4, 32'h00c0_0213, 0);
    do_retire(1'b1, 1'b0, 32'h102, 32'h0, 32'd2);

`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap_set", {31'b0, fetch_trap}, 32'd1);
    check("trap_addr", imem_addr, 32'h102);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("trap_req_low", {31'b0, imem_req}, 32'd0);
      check("trap_valid_low", {31'b0, instr_valid}, 32'd0);
      check("trap_sticky", {31'b0, fetch_trap}, 32'd1);
    end
`else
    wait_req();
    check("aligned_addr", imem_addr, 32'h100);
    check("no_trap", {31'b0, fetch_trap}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
